multicycle_control: RTL and testbench



---
 rtl/control_pkg.sv | 46 ++++
 rtl/control_decode.sv | 29 ++
 rtl/multicycle_control.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared opcode constants, FSM states, mux encodings and the decoded opcode
// class bundle for the multicycle control unit.
package control_pkg;

  localparam logic [5:0] OP_AND  = 6'b100000;
  localparam logic [5:0] OP_NOR  = 6'b100110;
  localparam logic [5:0] OP_NOT  = 6'b000100;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BLEU = 6'b010000;

  typedef enum logic [1:0] {
    S_EXEC = 2'd0,
    S_MEM  = 2'd1,
    S_BR2  = 2'd2
  } state_t;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_CONST = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_ALT   = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_JAL = 2'b01;
  localparam logic [1:0] PCSRC_BR  = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  typedef struct packed {
    logic is_r;
    logic is_nori;
    logic is_jr;
    logic is_jal;
    logic is_lw;
    logic is_sw;
    logic is_bleu;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-class decoder; exactly one class bit is set for any
// opcode, with unknown opcodes landing in is_illegal.
module control_decode
  import control_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] i_opcode,
  output op_class_t      o_class
);

  always_comb begin
    // NOTE: every bit gets a default before the case so no path leaves a
    // latch behind; the same pattern is used in every always_comb here.
    o_class = '0;
    case (i_opcode)
      OPW'(OP_AND), OPW'(OP_NOR), OPW'(OP_NOT),
      OPW'(OP_ROLV), OPW'(OP_RORV): o_class.is_r    = 1'b1;
      OPW'(OP_NORI):                o_class.is_nori = 1'b1;
      OPW'(OP_JR):                  o_class.is_jr   = 1'b1;
      OPW'(OP_JAL):                 o_class.is_jal  = 1'b1;
      OPW'(OP_LW):                  o_class.is_lw   = 1'b1;
      OPW'(OP_SW):                  o_class.is_sw   = 1'b1;
      OPW'(OP_BLEU):                o_class.is_bleu = 1'b1;
      default:                      o_class.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: single-cycle ops decode straight from ins, while
// loads/stores and branches walk a small FSM with a latched opcode.
module multicycle_control
  import control_pkg::*;
#(
  parameter int OPW     = 6,
  parameter int ALUW    = 5,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 32
) (
  input  logic            clock,
  input  logic            resetN,
  input  logic [31:0]     ins,
  input  logic            stall,
  input  logic            memAck,
  output logic            memReq,
  output logic            memToReg,
  output logic            memWrite,
  output logic            branchEnable,
  output logic            regDst,
  output logic            regWriteEnable,
  output logic            jump,
  output logic            jumpReg,
  output logic            PCWrite,
  output logic            IorD,
  output logic            IRWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSrc,
  output logic [ALUW-1:0] ALUControl,
  output logic            busy,
  output logic            illegalOp,
  output logic            memFault,
  output logic [CNTW-1:0] retired
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          r_state;
  logic [OPW-1:0]  r_opcode;
  logic [WCW-1:0]  r_wait;
  logic [CNTW-1:0] r_retired;

  state_t          w_next_state;
  logic [OPW-1:0]  w_live_op;
  op_class_t       w_live_cls;
  op_class_t       w_lat_cls;
  logic            w_ack;
  logic            w_timeout;
  logic            w_latch;
  logic            w_wait_clr;
  logic            w_wait_inc;
  logic            w_wr_ok;
  logic            w_unused_ins;

  logic            w_mem_req, w_mem_to_reg, w_mem_write, w_branch_en, w_reg_dst;
  logic            w_reg_we, w_jump, w_jump_reg, w_pc_write, w_iord, w_ir_write;
  logic            w_alu_src_a, w_illegal, w_fault;
  logic [1:0]      w_alu_src_b, w_pc_src;
  logic [ALUW-1:0] w_alu_ctl;

  assign w_live_op    = ins[31 -: OPW];
  assign w_unused_ins = ^ins[31-OPW:0];

  control_decode #(.OPW(OPW)) u_dec_live (
    .i_opcode (w_live_op),
    .o_class  (w_live_cls)
  );

  control_decode #(.OPW(OPW)) u_dec_lat (
    .i_opcode (r_opcode),
    .o_class  (w_lat_cls)
  );

  // A stalled cycle must not complete or abandon the memory access.
  assign w_ack     = memAck & ~stall;
  assign w_timeout = (TIMEOUT > 0) && (r_wait == WAIT_LAST) && !stall;

  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_wait_clr   = 1'b0;
    w_wait_inc   = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_write  = 1'b0;
    w_branch_en  = 1'b0;
    w_reg_dst    = 1'b0;
    w_reg_we     = 1'b0;
    w_jump       = 1'b0;
    w_jump_reg   = 1'b0;
    w_pc_write   = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_alu_src_a  = 1'b1;
    w_illegal    = 1'b0;
    w_fault      = 1'b0;
    w_alu_src_b  = SRCB_REG;
    w_pc_src     = PCSRC_SEQ;
    w_alu_ctl    = w_live_op[OPW-1 -: ALUW];

    case (r_state)
      S_EXEC: begin
        if (w_live_cls.is_r) begin
          w_reg_dst  = 1'b1;
          w_reg_we   = 1'b1;
          w_pc_write = 1'b1;
        end
        if (w_live_cls.is_nori) begin
          w_alu_src_b = SRCB_IMM;
          w_reg_we    = 1'b1;
          w_pc_write  = 1'b1;
        end
        if (w_live_cls.is_jr) begin
          w_jump      = 1'b1;
          w_jump_reg  = 1'b1;
          w_alu_src_b = SRCB_ALT;
          w_pc_src    = PCSRC_JR;
          w_pc_write  = 1'b1;
        end
        if (w_live_cls.is_jal) begin
          w_jump       = 1'b1;
          w_alu_src_b  = SRCB_ALT;
          w_pc_src     = PCSRC_JAL;
          w_mem_to_reg = 1'b1;
          w_reg_we     = 1'b1;
          w_pc_write   = 1'b1;
        end
        if (w_live_cls.is_lw || w_live_cls.is_sw) begin
          w_alu_src_b  = SRCB_IMM;
          w_ir_write   = 1'b1;
          w_latch      = 1'b1;
          w_wait_clr   = 1'b1;
          w_next_state = S_MEM;
        end
        if (w_live_cls.is_bleu) begin
          w_alu_src_a  = 1'b0;
          w_alu_src_b  = SRCB_ALT;
          w_branch_en  = 1'b1;
          w_latch      = 1'b1;
          w_next_state = S_BR2;
        end
        if (w_live_cls.is_illegal) begin
          w_illegal  = 1'b1;
          w_pc_write = 1'b1;
        end
      end

      S_MEM: begin
        w_alu_ctl   = r_opcode[OPW-1 -: ALUW];
        w_mem_req   = 1'b1;
        w_iord      = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_mem_write = w_lat_cls.is_sw;
        if (w_ack) begin
          w_pc_write = 1'b1;
          if (w_lat_cls.is_lw) begin
            w_mem_to_reg = 1'b1;
            w_reg_we     = 1'b1;
          end
          w_next_state = S_EXEC;
        end else if (w_timeout) begin
          w_fault      = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = S_EXEC;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_BR2: begin
        w_alu_ctl    = r_opcode[OPW-1 -: ALUW] | ALUW'(1);
        w_pc_src     = PCSRC_BR;
        w_pc_write   = 1'b1;
        w_next_state = S_EXEC;
      end

      default: w_next_state = S_EXEC;
    endcase
  end

  // NOTE: state lives behind an asynchronous reset and is only ever updated
  // with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state   <= S_EXEC;
      r_opcode  <= '0;
      r_wait    <= '0;
      r_retired <= '0;
    end else if (!stall) begin
      r_state <= w_next_state;
      if (w_latch) r_opcode <= w_live_op;
      if (w_wait_clr)
        r_wait <= '0;
      else if (w_wait_inc && (r_wait != '1))
        r_wait <= r_wait + 1'b1;
      if (w_pc_write) r_retired <= r_retired + 1'b1;
    end
  end

  // Outputs are forced to the reset pattern while resetN is low, and write
  // strobes are blocked for the duration of a stall.
  assign w_wr_ok        = resetN & ~stall;
  assign memReq         = w_wr_ok & w_mem_req;
  assign memWrite       = w_wr_ok & w_mem_write;
  assign regWriteEnable = w_wr_ok & w_reg_we;
  assign PCWrite        = w_wr_ok & w_pc_write;
  assign IRWrite        = w_wr_ok & w_ir_write;
  assign illegalOp      = w_wr_ok & w_illegal;
  assign memFault       = resetN & w_fault;
  assign memToReg       = resetN & w_mem_to_reg;
  assign branchEnable   = resetN & w_branch_en;
  assign regDst         = resetN & w_reg_dst;
  assign jump           = resetN & w_jump;
  assign jumpReg        = resetN & w_jump_reg;
  assign IorD           = resetN & w_iord;
  assign ALUSrcA        = ~resetN | w_alu_src_a;
  assign ALUSrcB        = resetN ? w_alu_src_b : 2'b00;
  assign PCSrc          = resetN ? w_pc_src : 2'b00;
  assign ALUControl     = resetN ? w_alu_ctl : '0;
  assign busy           = resetN & (r_state != S_EXEC);
  assign retired        = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a default instance plus a
// TIMEOUT=4 instance that shares the same stimulus.
module tb_multicycle_control;
  import control_pkg::*;

  localparam int CNTW = 32;

  typedef struct packed {
    logic       mem_req, mem_to_reg, mem_write, branch_en, reg_dst, reg_we;
    logic       jump, jump_reg, pc_write, iord, ir_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [4:0] alu_ctl;
    logic       busy, illegal, fault;
  } ctl_t;

  logic        clock = 1'b0;
  logic        resetN = 1'b1;
  logic        stall = 1'b1;
  logic        memAck = 1'b0;
  logic [31:0] ins = {OP_AND, 26'h0};

  logic memReq, memToReg, memWrite, branchEnable, regDst, regWriteEnable;
  logic jump, jumpReg, PCWrite, IorD, IRWrite, ALUSrcA, busy, illegalOp, memFault;
  logic [1:0] ALUSrcB, PCSrc;
  logic [4:0] ALUControl;
  logic [CNTW-1:0] retired;

  logic t_memReq, t_memToReg, t_memWrite, t_branchEnable, t_regDst, t_regWriteEnable;
  logic t_jump, t_jumpReg, t_PCWrite, t_IorD, t_IRWrite, t_ALUSrcA, t_busy, t_illegalOp, t_memFault;
  logic [1:0] t_ALUSrcB, t_PCSrc;
  logic [4:0] t_ALUControl;
  logic [CNTW-1:0] t_retired;

  ctl_t obs, obs4;
  assign obs  = {memReq, memToReg, memWrite, branchEnable, regDst, regWriteEnable,
                 jump, jumpReg, PCWrite, IorD, IRWrite, ALUSrcA, ALUSrcB, PCSrc,
                 ALUControl, busy, illegalOp, memFault};
  assign obs4 = {t_memReq, t_memToReg, t_memWrite, t_branchEnable, t_regDst, t_regWriteEnable,
                 t_jump, t_jumpReg, t_PCWrite, t_IorD, t_IRWrite, t_ALUSrcA, t_ALUSrcB, t_PCSrc,
                 t_ALUControl, t_busy, t_illegalOp, t_memFault};

  multicycle_control dut (
    .clock(clock), .resetN(resetN), .ins(ins), .stall(stall), .memAck(memAck),
    .memReq(memReq), .memToReg(memToReg), .memWrite(memWrite),
    .branchEnable(branchEnable), .regDst(regDst), .regWriteEnable(regWriteEnable),
    .jump(jump), .jumpReg(jumpReg), .PCWrite(PCWrite), .IorD(IorD),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .busy(busy), .illegalOp(illegalOp),
    .memFault(memFault), .retired(retired)
  );

  multicycle_control #(.TIMEOUT(4)) dut4 (
    .clock(clock), .resetN(resetN), .ins(ins), .stall(stall), .memAck(memAck),
    .memReq(t_memReq), .memToReg(t_memToReg), .memWrite(t_memWrite),
    .branchEnable(t_branchEnable), .regDst(t_regDst), .regWriteEnable(t_regWriteEnable),
    .jump(t_jump), .jumpReg(t_jumpReg), .PCWrite(t_PCWrite), .IorD(t_IorD),
    .IRWrite(t_IRWrite), .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB), .PCSrc(t_PCSrc),
    .ALUControl(t_ALUControl), .busy(t_busy), .illegalOp(t_illegalOp),
    .memFault(t_memFault), .retired(t_retired)
  );

  always #5 clock = ~clock;

  ctl_t            sb[$];
  int              checks = 0;
  int              errors = 0;
  logic [CNTW-1:0] exp_ret = '0;

  // Idle pattern for a given opcode: only ALUSrcA high, ALUControl = top 5 bits.
  function automatic ctl_t base(input logic [5:0] op);
    ctl_t c;
    c = '0;
    c.alu_src_a = 1'b1;
    c.alu_ctl   = op[5:1];
    return c;
  endfunction

  function automatic ctl_t mem_wait(input logic [5:0] op);
    ctl_t c;
    c = base(op);
    c.mem_req   = 1'b1;
    c.iord      = 1'b1;
    c.alu_src_b = 2'b10;
    c.mem_write = (op == OP_SW);
    c.busy      = 1'b1;
    return c;
  endfunction

  function automatic ctl_t mem_entry(input logic [5:0] op);
    ctl_t c;
    c = base(op);
    c.alu_src_b = 2'b10;
    c.ir_write  = 1'b1;
    return c;
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue its expectation.
  task automatic drive(input logic [5:0] op, input logic s, input logic a, input ctl_t e);
    @(posedge clock);
    #1;
    ins    = {op, 26'($urandom)};
    stall  = s;
    memAck = a;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    ctl_t exp;
    #1 resetN = 1'b0;
    #2;
    sb.push_back(base(6'b000000));
    exp = sb.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, exp);
    end
    checks++;
    if (retired !== '0) begin
      errors++;
      $display("FAIL reset_retired got=%0d exp=0", retired);
    end
    @(posedge clock);
    #1 resetN = 1'b1;
  endtask

  task automatic test_and();
    ctl_t e, exp;
    e = base(OP_AND);
    e.reg_dst = 1'b1; e.reg_we = 1'b1; e.pc_write = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(OP_AND, 1'b0, 1'b0, e);
      @(negedge clock);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL and[%0d] got=%h exp=%h", i, obs, exp);
      end
      checks++;
      if (retired !== exp_ret) begin
        errors++;
        $display("FAIL and_retired[%0d] got=%0d exp=%0d", i, retired, exp_ret);
      end
      if (exp.pc_write) exp_ret++;
    end
  endtask

  task automatic test_single_cycle();
    logic [5:0] ops[7];
    ctl_t       e[7];
    ctl_t       exp;
    ops = '{OP_NORI, OP_JR, OP_JAL, OP_NOT, OP_NOR, OP_ROLV, OP_RORV};
    for (int i = 0; i < 7; i++) begin
      e[i] = base(ops[i]);
      e[i].pc_write = 1'b1;
    end
    e[0].alu_src_b = 2'b10; e[0].reg_we = 1'b1;
    e[1].jump = 1'b1; e[1].jump_reg = 1'b1; e[1].alu_src_b = 2'b11; e[1].pc_src = 2'b11;
    e[2].jump = 1'b1; e[2].alu_src_b = 2'b11; e[2].pc_src = 2'b01;
    e[2].mem_to_reg = 1'b1; e[2].reg_we = 1'b1;
    for (int i = 3; i < 7; i++) begin
      e[i].reg_dst = 1'b1; e[i].reg_we = 1'b1;
    end
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], 1'b0, 1'b0, e[i]);
      @(negedge clock);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single[%0d] op=%b got=%h exp=%h", i, ops[i], obs, exp);
      end
      checks++;
      if (retired !== exp_ret) begin
        errors++;
        $display("FAIL single_retired[%0d] got=%0d exp=%0d", i, retired, exp_ret);
      end
      if (exp.pc_write) exp_ret++;
    end
  endtask

  task automatic test_lw();
    logic [5:0] ops[5];
    logic       ack[5];
    ctl_t       e[5];
    ctl_t       exp;
    // ins changes while the load waits; outputs must follow the latched LW.
    ops = '{OP_LW, OP_AND, OP_NOR, OP_JR, OP_BLEU};
    ack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    e[0] = mem_entry(OP_LW);
    for (int i = 1; i < 5; i++) e[i] = mem_wait(OP_LW);
    e[4].pc_write = 1'b1; e[4].mem_to_reg = 1'b1; e[4].reg_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], 1'b0, ack[i], e[i]);
      @(negedge clock);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lw[%0d] got=%h exp=%h", i, obs, exp);
      end
      checks++;
      if (retired !== exp_ret) begin
        errors++;
        $display("FAIL lw_retired[%0d] got=%0d exp=%0d", i, retired, exp_ret);
      end
      if (exp.pc_write) exp_ret++;
    end
  endtask

  task automatic test_bleu();
    ctl_t e[2];
    ctl_t exp;
    e[0] = base(OP_BLEU);
    e[0].alu_src_a = 1'b0; e[0].alu_src_b = 2'b11; e[0].branch_en = 1'b1;
    e[1] = base(OP_BLEU);
    e[1].alu_ctl = 5'b01001; e[1].pc_src = 2'b10; e[1].pc_write = 1'b1; e[1].busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(i == 0 ? OP_BLEU : OP_JAL, 1'b0, 1'b0, e[i]);
      @(negedge clock);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bleu[%0d] got=%h exp=%h", i, obs, exp);
      end
      checks++;
      if (retired !== exp_ret) begin
        errors++;
        $display("FAIL bleu_retired[%0d] got=%0d exp=%0d", i, retired, exp_ret);
      end
      if (exp.pc_write) exp_ret++;
    end
  endtask

  task automatic test_illegal_stall();
    logic [5:0] ops[7];
    logic       stl[7];
    logic       ack[7];
    ctl_t       e[7];
    ctl_t       exp;
    ops = '{6'b111111, OP_AND, OP_LW, OP_AND, OP_AND, OP_AND, OP_AND};
    stl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ack = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    e[0] = base(6'b111111); e[0].illegal = 1'b1; e[0].pc_write = 1'b1;
    e[1] = base(OP_AND); e[1].reg_dst = 1'b1;
    e[2] = mem_entry(OP_LW);
    e[3] = mem_wait(OP_LW); e[3].mem_req = 1'b0;
    e[4] = mem_wait(OP_LW);
    e[5] = mem_wait(OP_LW);
    e[5].pc_write = 1'b1; e[5].mem_to_reg = 1'b1; e[5].reg_we = 1'b1;
    e[6] = base(OP_AND); e[6].reg_dst = 1'b1; e[6].reg_we = 1'b1; e[6].pc_write = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], stl[i], ack[i], e[i]);
      @(negedge clock);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL illegal_stall[%0d] got=%h exp=%h", i, obs, exp);
      end
      checks++;
      if (retired !== exp_ret) begin
        errors++;
        $display("FAIL illegal_stall_retired[%0d] got=%0d exp=%0d", i, retired, exp_ret);
      end
      if (exp.pc_write) exp_ret++;
    end
  endtask

  task automatic test_reset_mid();
    ctl_t e[4];
    ctl_t exp;
    e[0] = mem_entry(OP_LW);
    e[1] = mem_wait(OP_LW);
    e[2] = base(OP_AND); e[2].reg_dst = 1'b1; e[2].reg_we = 1'b1; e[2].pc_write = 1'b1;
    e[3] = e[2];
    for (int i = 0; i < 4; i++) begin
      drive(i == 0 ? OP_LW : OP_AND, 1'b0, 1'b0, e[i]);
      @(negedge clock);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid[%0d] got=%h exp=%h", i, obs, exp);
      end
      checks++;
      if (retired !== exp_ret) begin
        errors++;
        $display("FAIL reset_mid_retired[%0d] got=%0d exp=%0d", i, retired, exp_ret);
      end
      if (exp.pc_write) exp_ret++;
      if (i == 1) begin
        // Pull reset between edges while the load is pending in S_MEM.
        #2;
        resetN = 1'b0;
        stall  = 1'b1;
        #1;
        exp_ret = '0;
        sb.push_back(base(6'b000000));
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL reset_async got=%h exp=%h", obs, exp);
        end
        checks++;
        if (retired !== exp_ret) begin
          errors++;
          $display("FAIL reset_async_retired got=%0d exp=0", retired);
        end
        @(posedge clock);
        #1 resetN = 1'b1;
      end
    end
  endtask

  task automatic test_timeout();
    ctl_t e[6];
    ctl_t exp;
    e[0] = mem_entry(OP_SW);
    for (int i = 1; i < 5; i++) e[i] = mem_wait(OP_SW);
    e[4].fault = 1'b1; e[4].pc_write = 1'b1;
    e[5] = base(OP_AND); e[5].reg_dst = 1'b1; e[5].reg_we = 1'b1; e[5].pc_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(i < 5 ? OP_SW : OP_AND, 1'b0, 1'b0, e[i]);
      @(negedge clock);
      exp = sb.pop_front();
      checks++;
      if (obs4 !== exp) begin
        errors++;
        $display("FAIL timeout[%0d] got=%h exp=%h", i, obs4, exp);
      end
      checks++;
      if (t_retired !== exp_ret) begin
        errors++;
        $display("FAIL timeout_retired[%0d] got=%0d exp=%0d", i, t_retired, exp_ret);
      end
      if (exp.pc_write) exp_ret++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_and();
    test_single_cycle();
    test_lw();
    test_bleu();
    test_illegal_stall();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
